// File: rtl/saleterm_pkg.sv
// Shared sale-terminal definitions: catalogue table, widths and FSM state type.
// The catalogue table is also used by the barcode decode side.
package saleterm_pkg;

    localparam int PRODUCT_COUNT = 12;
    localparam int NUM_DIGITS    = 4;
    localparam int DIGIT_W       = 4;
    localparam int BARCODE_W     = NUM_DIGITS * DIGIT_W;

    localparam logic [3:0] PRODUCT_ID_INVALID = 4'hF;

    // Barcode per ProductID, digit 3 in the top nibble.
    localparam logic [BARCODE_W-1:0] CATALOGUE [PRODUCT_COUNT] = '{
        16'h3124, 16'h4132, 16'h4133, 16'h3121, 16'h3133, 16'h3214,
        16'h2134, 16'h2144, 16'h3112, 16'h4321, 16'h1342, 16'h1213
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_FIN
    } emit_state_e;

endpackage

// File: rtl/productid2barcode.sv
// Combinational catalogue lookup: ProductID -> 16-bit barcode plus valid flag.
// IDs outside the catalogue return barcode 0 with id_valid low.
module productid2barcode
    import saleterm_pkg::*;
(
    input  logic [3:0]           product_id,
    output logic [BARCODE_W-1:0] barcode,
    output logic                 id_valid
);

    // Linear match keeps the index in range for the unused IDs 12..15.
    always_comb begin
        barcode  = '0;
        id_valid = 1'b0;
        for (int i = 0; i < PRODUCT_COUNT; i++) begin
            if (product_id == 4'(i)) begin
                barcode  = CATALOGUE[i];
                id_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/product_barcode_emitter.sv
// Serial barcode emitter: latches a ProductID's barcode and emits it one digit
// per valid/ready handshake, most significant digit first.
// Optional feature macro: BARCODE_CHECKSUM_EN appends a check digit
// ((d3+d2+d1+d0) mod 4) + 1 after digit 0 and moves digit_last onto it.
//
//   state | meaning
//   IDLE  | waiting for start; rejects out-of-catalogue IDs with id_error
//   SEND  | digit presented, held until digit_ready
//   GAP   | idle spacing after an accepted (non-final) digit
//   FIN   | done pulse, back to IDLE next cycle
module product_barcode_emitter
    import saleterm_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         product_id,
    output logic [DIGIT_W-1:0] digit_out,
    output logic               digit_valid,
    input  logic               digit_ready,
    output logic               digit_last,
    output logic               busy,
    output logic               done,
    output logic               id_error
);

`ifdef BARCODE_CHECKSUM_EN
    localparam int FRAME_LEN = NUM_DIGITS + 1;
`else
    localparam int FRAME_LEN = NUM_DIGITS;
`endif
    localparam int         GAP_W    = 4;
    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    emit_state_e          state_q, state_d;
    logic [BARCODE_W-1:0] barcode_q, barcode_d;
    logic [2:0]           idx_q, idx_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [DIGIT_W-1:0]   digit_out_q, digit_out_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [BARCODE_W-1:0] rom_barcode;
    logic                 rom_valid;
    logic [2:0]           idx_nxt;

    productid2barcode u_rom (
        .product_id (product_id),
        .barcode    (rom_barcode),
        .id_valid   (rom_valid)
    );

    function automatic logic [DIGIT_W-1:0] digit_at(input logic [BARCODE_W-1:0] bc,
                                                    input logic [2:0] idx);
        logic [DIGIT_W-1:0] d;
`ifdef BARCODE_CHECKSUM_EN
        logic [5:0] sum;
        sum = 6'(bc[15:12]) + 6'(bc[11:8]) + 6'(bc[7:4]) + 6'(bc[3:0]);
`endif
        d = '0;
        case (idx)
            3'd0:    d = bc[15:12];
            3'd1:    d = bc[11:8];
            3'd2:    d = bc[7:4];
            3'd3:    d = bc[3:0];
`ifdef BARCODE_CHECKSUM_EN
            3'd4:    d = {2'b00, sum[1:0]} + 4'd1;
`endif
            default: d = '0;
        endcase
        return d;
    endfunction

    assign idx_nxt = idx_q + 3'd1;

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        barcode_d   = barcode_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        digit_out_d = digit_out_q;
        valid_d     = valid_q;
        last_d      = last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (start) begin
                    if (rom_valid) begin
                        state_d     = ST_SEND;
                        barcode_d   = rom_barcode;
                        idx_d       = 3'd0;
                        digit_out_d = rom_barcode[15:12];
                        valid_d     = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (valid_q && digit_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FIN;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_nxt;
                        if (GAP_CYCLES > 0) begin
                            state_d = ST_GAP;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            gap_d   = GAP_W'(GAP_CYCLES - 1);
                        end else begin
                            digit_out_d = digit_at(barcode_q, idx_nxt);
                            last_d      = (idx_nxt == LAST_IDX);
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d     = ST_SEND;
                    valid_d     = 1'b1;
                    digit_out_d = digit_at(barcode_q, idx_q);
                    last_d      = (idx_q == LAST_IDX);
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            barcode_q   <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            digit_out_q <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            barcode_q   <= barcode_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            digit_out_q <= digit_out_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign digit_out   = digit_out_q;
    assign digit_valid = valid_q;
    assign digit_last  = last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_error    = err_q;

endmodule

// File: tb/tb_product_barcode_emitter.sv
// Directed bench for product_barcode_emitter: one gapless instance and one
// instance with GAP_CYCLES=2. Honours BARCODE_CHECKSUM_EN for expected frames.
module tb_product_barcode_emitter;

`ifdef BARCODE_CHECKSUM_EN
    localparam int L = 5;
`else
    localparam int L = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       ready;
    logic       sel_gap;
    logic [3:0] pid;
    logic       start_a, start_b;

    logic [3:0] a_digit, b_digit, m_digit;
    logic a_valid, a_last, a_busy, a_done, a_err;
    logic b_valid, b_last, b_busy, b_done, b_err;
    logic m_valid, m_last, m_busy, m_done, m_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] ld    [32];
    logic       lv    [32];
    logic       ll    [32];
    logic       lbusy [32];
    logic       ldone [32];
    logic       lerr  [32];
    logic       lrdy  [32];

    always #5 clk = ~clk;

    assign start_a = start & ~sel_gap;
    assign start_b = start & sel_gap;
    assign m_digit = sel_gap ? b_digit : a_digit;
    assign m_valid = sel_gap ? b_valid : a_valid;
    assign m_last  = sel_gap ? b_last  : a_last;
    assign m_busy  = sel_gap ? b_busy  : a_busy;
    assign m_done  = sel_gap ? b_done  : a_done;
    assign m_err   = sel_gap ? b_err   : a_err;

    product_barcode_emitter #(.GAP_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .product_id(pid),
        .digit_out(a_digit), .digit_valid(a_valid), .digit_ready(ready),
        .digit_last(a_last), .busy(a_busy), .done(a_done), .id_error(a_err)
    );

    product_barcode_emitter #(.GAP_CYCLES(2)) dut_gap (
        .clk(clk), .rst_n(rst_n), .start(start_b), .product_id(pid),
        .digit_out(b_digit), .digit_valid(b_valid), .digit_ready(ready),
        .digit_last(b_last), .busy(b_busy), .done(b_done), .id_error(b_err)
    );

    // Start a frame, then log outputs for ncyc cycles (cycle 1 = cycle after start).
    task automatic run(input logic [3:0] id, input int ncyc, input int inj_cyc,
                       input logic [3:0] inj_id, input int rst_cyc,
                       input int st_from, input int st_to);
        @(posedge clk); #1;
        pid   = id;
        start = 1'b1;
        ready = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            start = (k == inj_cyc);
            if (k == inj_cyc) pid = inj_id;
            rst_n = (k != rst_cyc);
            ready = !(k >= st_from && k <= st_to);
            @(negedge clk);
            ld[k] = m_digit; lv[k] = m_valid; ll[k] = m_last;
            lbusy[k] = m_busy; ldone[k] = m_done; lerr[k] = m_err; lrdy[k] = ready;
        end
        start = 1'b0;
        ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({a_digit, a_valid, a_last, a_busy, a_done, a_err} !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {a_digit, a_valid, a_last, a_busy, a_done, a_err});
        end
        n_checks++;
        if ({b_digit, b_valid, b_last, b_busy, b_done, b_err} !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_gap: got %h expected 0", {b_digit, b_valid, b_last, b_busy, b_done, b_err});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: valid=%b busy=%b expected 0 0", a_valid, a_busy);
        end
    endtask

    task automatic test_id0_streaming();
        int exp [5] = '{3, 1, 2, 4, 3};
        run(4'd0, L + 3, 0, 4'd0, 0, 0, -1);
        for (int k = 1; k <= L + 2; k++) begin
            n_checks++;
            if (lv[k] !== (k <= L)) begin
                n_fail++; $display("FAIL id0_valid c%0d: got %b expected %b", k, lv[k], (k <= L));
            end
            if (k <= L) begin
                n_checks++;
                if (ld[k] !== 4'(exp[k-1])) begin
                    n_fail++; $display("FAIL id0_digit c%0d: got %0d expected %0d", k, ld[k], exp[k-1]);
                end
            end
            n_checks++;
            if (ll[k] !== (k == L)) begin
                n_fail++; $display("FAIL id0_last c%0d: got %b expected %b", k, ll[k], (k == L));
            end
            n_checks++;
            if (ldone[k] !== (k == L + 1)) begin
                n_fail++; $display("FAIL id0_done c%0d: got %b expected %b", k, ldone[k], (k == L + 1));
            end
            n_checks++;
            if (lbusy[k] !== (k <= L + 1)) begin
                n_fail++; $display("FAIL id0_busy c%0d: got %b expected %b", k, lbusy[k], (k <= L + 1));
            end
        end
    endtask

    task automatic test_stall();
        int exp [5] = '{4, 3, 2, 1, 3};
        int n = 0;
        int ndone = 0;
        run(4'd9, L + 8, 0, 4'd0, 0, 2, 4);
        for (int k = 2; k <= 5; k++) begin
            n_checks++;
            if (lv[k] !== 1'b1 || ld[k] !== 4'd3 || ll[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold c%0d: got valid=%b digit=%0d last=%b expected 1 3 0", k, lv[k], ld[k], ll[k]);
            end
        end
        for (int k = 1; k <= L + 8; k++) begin
            if (ldone[k]) ndone++;
            if (lv[k] && lrdy[k]) begin
                n_checks++;
                if (n >= L || ld[k] !== 4'(exp[n]) || ll[k] !== (n == L - 1)) begin
                    n_fail++;
                    $display("FAIL stall_seq #%0d: got digit=%0d last=%b expected %0d %b", n, ld[k], ll[k], (n < L) ? exp[n] : -1, (n == L - 1));
                end
                n++;
            end
        end
        n_checks++;
        if (n != L) begin n_fail++; $display("FAIL stall_count: got %0d expected %0d", n, L); end
        n_checks++;
        if (ndone != 1) begin n_fail++; $display("FAIL stall_done: got %0d pulses expected 1", ndone); end
    endtask

    task automatic test_id_error(input logic [3:0] id);
        run(id, 4, 0, 4'd0, 0, 0, -1);
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (lerr[k] !== (k == 1)) begin
                n_fail++; $display("FAIL id_error_%0d c%0d: got %b expected %b", id, k, lerr[k], (k == 1));
            end
            n_checks++;
            if (lv[k] !== 1'b0 || lbusy[k] !== 1'b0) begin
                n_fail++; $display("FAIL id_error_quiet_%0d c%0d: got valid=%b busy=%b expected 0 0", id, k, lv[k], lbusy[k]);
            end
        end
    endtask

    task automatic test_gap();
        int exp [5] = '{1, 2, 1, 3, 4};
        int n = 0;
        logic ev;
        sel_gap = 1'b1;
        run(4'd11, 3 * L + 1, 0, 4'd0, 0, 0, -1);
        sel_gap = 1'b0;
        for (int k = 1; k <= 3 * L + 1; k++) begin
            ev = ((k - 1) % 3 == 0) && (k <= 3 * L - 2);
            n_checks++;
            if (lv[k] !== ev) begin
                n_fail++; $display("FAIL gap_valid c%0d: got %b expected %b", k, lv[k], ev);
            end
            n_checks++;
            if (ldone[k] !== (k == 3 * L - 1)) begin
                n_fail++; $display("FAIL gap_done c%0d: got %b expected %b", k, ldone[k], (k == 3 * L - 1));
            end
            if (lv[k] && lrdy[k]) begin
                n_checks++;
                if (n >= L || ld[k] !== 4'(exp[n]) || ll[k] !== (n == L - 1)) begin
                    n_fail++;
                    $display("FAIL gap_seq #%0d: got digit=%0d last=%b expected %0d %b", n, ld[k], ll[k], (n < L) ? exp[n] : -1, (n == L - 1));
                end
                n++;
            end
        end
        n_checks++;
        if (n != L) begin n_fail++; $display("FAIL gap_count: got %0d expected %0d", n, L); end
    endtask

    task automatic test_start_while_busy();
        int exp [5] = '{3, 1, 2, 1, 4};
        int n = 0;
        int ndone = 0;
        run(4'd3, L + 6, 2, 4'd5, 0, 0, -1);
        for (int k = 1; k <= L + 6; k++) begin
            if (ldone[k]) ndone++;
            if (lv[k] && lrdy[k]) begin
                n_checks++;
                if (n >= L || ld[k] !== 4'(exp[n])) begin
                    n_fail++;
                    $display("FAIL busy_start_seq #%0d: got %0d expected %0d", n, ld[k], (n < L) ? exp[n] : -1);
                end
                n++;
            end
        end
        n_checks++;
        if (n != L) begin n_fail++; $display("FAIL busy_start_count: got %0d expected %0d", n, L); end
        n_checks++;
        if (ndone != 1) begin n_fail++; $display("FAIL busy_start_done: got %0d pulses expected 1", ndone); end
        n_checks++;
        if (lbusy[L + 6] !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: got busy=%b expected 0", lbusy[L + 6]); end
    endtask

    task automatic test_start_on_done();
        int exp [5] = '{2, 1, 4, 4, 4};
        run(4'd7, L + 5, L + 1, 4'd5, 0, 0, -1);
        for (int k = 1; k <= L; k++) begin
            n_checks++;
            if (lv[k] !== 1'b1 || ld[k] !== 4'(exp[k-1])) begin
                n_fail++; $display("FAIL done_start_digit c%0d: got valid=%b digit=%0d expected 1 %0d", k, lv[k], ld[k], exp[k-1]);
            end
        end
        for (int k = L + 2; k <= L + 5; k++) begin
            n_checks++;
            if (lv[k] !== 1'b0 || lbusy[k] !== 1'b0 || ldone[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL done_start_ignored c%0d: got valid=%b busy=%b done=%b expected 0 0 0", k, lv[k], lbusy[k], ldone[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        run(4'd3, 10, 0, 4'd0, 3, 0, -1);
        n_checks++;
        if ({ld[3], lv[3], ll[3], lbusy[3], ldone[3], lerr[3]} !== 9'h0) begin
            n_fail++;
            $display("FAIL midreset_clear: got %h expected 0", {ld[3], lv[3], ll[3], lbusy[3], ldone[3], lerr[3]});
        end
        for (int k = 1; k <= 10; k++) begin
            if (lv[k] && lrdy[k]) n++;
            if (k >= 3) begin
                n_checks++;
                if (lv[k] !== 1'b0 || lbusy[k] !== 1'b0 || ldone[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midreset_quiet c%0d: got valid=%b busy=%b done=%b expected 0 0 0", k, lv[k], lbusy[k], ldone[k]);
                end
            end
        end
        n_checks++;
        if (n != 2 || ld[1] !== 4'd3 || ld[2] !== 4'd1) begin
            n_fail++; $display("FAIL midreset_partial: got %0d digits (%0d,%0d) expected 2 (3,1)", n, ld[1], ld[2]);
        end
    endtask

    task automatic test_id10();
        int exp [5] = '{1, 3, 4, 2, 3};
        run(4'd10, L + 2, 0, 4'd0, 0, 0, -1);
        for (int k = 1; k <= L; k++) begin
            n_checks++;
            if (lv[k] !== 1'b1 || ld[k] !== 4'(exp[k-1]) || ll[k] !== (k == L)) begin
                n_fail++;
                $display("FAIL id10_digit c%0d: got valid=%b digit=%0d last=%b expected 1 %0d %b", k, lv[k], ld[k], ll[k], exp[k-1], (k == L));
            end
        end
        n_checks++;
        if (ldone[L + 1] !== 1'b1) begin n_fail++; $display("FAIL id10_done: got %b expected 1", ldone[L + 1]); end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        ready   = 1'b0;
        sel_gap = 1'b0;
        pid     = 4'd0;
        test_reset();
        test_id0_streaming();
        test_stall();
        test_id_error(4'd12);
        test_id_error(4'd15);
        test_gap();
        test_start_while_busy();
        test_start_on_done();
        test_reset_mid_frame();
        test_id10();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
